text_buffer_uart_dump: RTL and testbench

- Read-side counterpart to the UART-to-text-buffer receive path: on request, reads all 4 rows x 32 columns of the character RAM through its read port and transmits them over UART TX as 8N1 serial.
- Emits CR/LF after each row, so a terminal shows the same 4x32 grid as the VGA text display.
- Sits beside the display path in top: drives the RAM read address (ry, rx) when dumping, and drives RsTx.

---
 rtl/text_buffer_uart_dump_pkg.sv | 30 +++
 rtl/text_buffer_uart_dump_if.sv | 38 +++
 rtl/uart_tx_core.sv | 81 ++++++++
 rtl/text_buffer_uart_dump.sv | 153 +++++++++++++++
 tb/tb_text_buffer_uart_dump.sv | 312 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/text_buffer_uart_dump_pkg.sv
// Shared constants and types for the text buffer receive and dump paths.
// Both sides agree on grid size, control characters and the dump FSM encoding.
package text_buffer_uart_dump_pkg;

    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam logic [7:0] ASCII_SPACE = 8'h20;

    localparam int unsigned TEXT_COLS = 32;
    localparam int unsigned TEXT_ROWS = 4;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StLatch,
        StSend,
        StCr,
        StLf,
        StFin
    } dump_state_e;

    // Control codes and DEL/high bytes would upset a terminal; show them as blanks.
    function automatic logic [7:0] printable(input logic [7:0] c);
        if (c < ASCII_SPACE || c >= 8'h7F) begin
            return ASCII_SPACE;
        end
        return c;
    endfunction

endpackage

// File: rtl/text_buffer_uart_dump_if.sv
// Dump request/status, character RAM read port and serial line of the dump block.
// The slave modport is the dump block; the master side is the requester plus RAM.
interface text_buffer_uart_dump_if
    import text_buffer_uart_dump_pkg::*;
#(
    parameter int unsigned COLS = TEXT_COLS,
    parameter int unsigned ROWS = TEXT_ROWS
) ();

    logic                      start;
    logic [7:0]                rdata;
    logic [$clog2(ROWS)-1:0]   ry;
    logic [$clog2(COLS)-1:0]   rx;
    logic                      tx;
    logic                      busy;
    logic                      done;

    modport slave (
        input  start,
        input  rdata,
        output ry,
        output rx,
        output tx,
        output busy,
        output done
    );

    modport master (
        output start,
        output rdata,
        input  ry,
        input  rx,
        input  tx,
        input  busy,
        input  done
    );

endinterface

// File: rtl/uart_tx_core.sv
// 8N1 serial transmitter: start bit, 8 data bits LSB first, one stop bit.
// Each bit is held for BIT_DIV clocks; tx_done pulses for one clock after the stop bit.
module uart_tx_core #(
    parameter int unsigned BIT_DIV = 10416
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    output logic       tx,
    output logic       tx_busy,
    output logic       tx_done
);

    localparam int unsigned DIV_W = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BIT_DIV - 1);
    localparam logic [3:0] BIT_LAST = 4'd9;

    logic [DIV_W-1:0] div_q, div_d;
    logic [3:0]       bit_q, bit_d;
    logic [8:0]       shift_q, shift_d;
    logic             tx_q, tx_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    always_comb begin
        div_d   = div_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        if (!busy_q) begin
            if (tx_start) begin
                busy_d  = 1'b1;
                tx_d    = 1'b0;
                shift_d = {1'b1, tx_data};
                div_d   = '0;
                bit_d   = '0;
            end
        end else if (div_q == DIV_LAST) begin
            div_d = '0;
            if (bit_q == BIT_LAST) begin
                busy_d = 1'b0;
                done_d = 1'b1;
                tx_d   = 1'b1;
            end else begin
                // The stop bit is the top of the shift register, so it falls out last.
                tx_d    = shift_q[0];
                shift_d = {1'b1, shift_q[8:1]};
                bit_d   = bit_q + 4'd1;
            end
        end else begin
            div_d = div_q + DIV_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_q   <= '0;
            bit_q   <= '0;
            shift_q <= '1;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            div_q   <= div_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign tx      = tx_q;
    assign tx_busy = busy_q;
    assign tx_done = done_q;

endmodule

// File: rtl/text_buffer_uart_dump.sv
// Streams the whole character RAM out over UART as 8N1, appending CR/LF after each row,
// so a terminal mirrors the VGA text grid. Owns the RAM read address while dumping.
module text_buffer_uart_dump
    import text_buffer_uart_dump_pkg::*;
#(
    parameter int unsigned CLK_FREQ = 100000000,
    parameter int unsigned BAUD     = 9600,
    parameter int unsigned COLS     = TEXT_COLS,
    parameter int unsigned ROWS     = TEXT_ROWS
) (
    input  logic                   clk,
    input  logic                   reset,
    text_buffer_uart_dump_if.slave bus
);

    localparam int unsigned BIT_DIV = CLK_FREQ / BAUD;
    localparam int unsigned RX_W    = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int unsigned RY_W    = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam logic [RX_W-1:0] RX_LAST = RX_W'(COLS - 1);
    localparam logic [RY_W-1:0] RY_LAST = RY_W'(ROWS - 1);

    dump_state_e     state_q, state_d;
    logic [RY_W-1:0] ry_q, ry_d;
    logic [RX_W-1:0] rx_q, rx_d;
    logic [7:0]      byte_q, byte_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            launched_q, launched_d;

    logic            tx_start;
    logic [7:0]      tx_data;
    logic            tx_line;
    logic            tx_busy;
    logic            tx_done;

    always_comb begin
        state_d    = state_q;
        ry_d       = ry_q;
        rx_d       = rx_q;
        byte_d     = byte_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        launched_d = launched_q;
        tx_start   = 1'b0;
        tx_data    = byte_q;

        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    ry_d    = '0;
                    rx_d    = '0;
                    busy_d  = 1'b1;
                    state_d = StFetch;
                end
            end
            StFetch: begin
                state_d = StLatch;
            end
            StLatch: begin
                byte_d  = printable(bus.rdata);
                state_d = StSend;
            end
            StSend: begin
                tx_start = !launched_q;
                if (tx_done) begin
                    if (rx_q == RX_LAST) begin
                        state_d = StCr;
                    end else begin
                        rx_d    = rx_q + RX_W'(1);
                        state_d = StFetch;
                    end
                end
            end
            StCr: begin
                tx_start = !launched_q;
                tx_data  = ASCII_CR;
                if (tx_done) begin
                    state_d = StLf;
                end
            end
            StLf: begin
                tx_start = !launched_q;
                tx_data  = ASCII_LF;
                if (tx_done) begin
                    if (ry_q == RY_LAST) begin
                        ry_d    = '0;
                        rx_d    = '0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = StFin;
                    end else begin
                        ry_d    = ry_q + RY_W'(1);
                        rx_d    = '0;
                        state_d = StFetch;
                    end
                end
            end
            StFin: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Request a byte once per character slot; the core's done ends the slot.
        if (tx_start && !tx_busy) begin
            launched_d = 1'b1;
        end
        if (tx_done) begin
            launched_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            ry_q       <= '0;
            rx_q       <= '0;
            byte_q     <= ASCII_SPACE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            launched_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ry_q       <= ry_d;
            rx_q       <= rx_d;
            byte_q     <= byte_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            launched_q <= launched_d;
        end
    end

    uart_tx_core #(
        .BIT_DIV (BIT_DIV)
    ) u_tx (
        .clk      (clk),
        .reset    (reset),
        .tx_start (tx_start),
        .tx_data  (tx_data),
        .tx       (tx_line),
        .tx_busy  (tx_busy),
        .tx_done  (tx_done)
    );

    assign bus.ry   = ry_q;
    assign bus.rx   = rx_q;
    assign bus.tx   = tx_line;
    assign bus.busy = busy_q;
    assign bus.done = done_q;

endmodule

// File: tb/tb_text_buffer_uart_dump.sv
// Directed bench for text_buffer_uart_dump: RAM model, serial decoder and per-feature tasks.
// Runs with BIT_DIV = 10 so a full 136-byte dump stays short.
module tb_text_buffer_uart_dump;
    import text_buffer_uart_dump_pkg::*;

    localparam int unsigned CLK_FREQ = 1000;
    localparam int unsigned BAUD     = 100;
    localparam int          NBYTES   = 136;
    localparam int          BUDGET   = 20000;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    text_buffer_uart_dump_if dif ();

    text_buffer_uart_dump #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD     (BAUD)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (dif)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    logic [7:0] ram [4][32];
    always @(posedge clk) dif.rdata <= ram[dif.ry][dif.rx];

    // Serial decoder: samples mid-bit on falling clock edges.
    logic [7:0] rx_bytes [$];
    logic [7:0] mon_sh;
    int         mon_cnt;
    bit         mon_act = 1'b0;
    int         frame_err = 0;

    always @(negedge clk) begin
        if (reset !== 1'b1) begin
            mon_act = 1'b0;
        end else if (!mon_act) begin
            if (dif.tx === 1'b0) begin
                mon_act = 1'b1;
                mon_cnt = 0;
            end
        end else begin
            mon_cnt++;
            if (mon_cnt == 5 && dif.tx !== 1'b0) frame_err++;
            if (mon_cnt >= 15 && mon_cnt <= 85 && (mon_cnt - 15) % 10 == 0)
                mon_sh[(mon_cnt - 15) / 10] = dif.tx;
            if (mon_cnt == 95) begin
                if (dif.tx !== 1'b1) frame_err++;
                rx_bytes.push_back(mon_sh);
                mon_act = 1'b0;
            end
        end
    end

    int done_cnt = 0;
    int done_busy_err = 0;
    int done_wide_err = 0;
    bit done_prev = 1'b0;

    always @(negedge clk) begin
        if (dif.done === 1'b1) begin
            done_cnt++;
            if (dif.busy !== 1'b0) done_busy_err++;
            if (done_prev) done_wide_err++;
        end
        done_prev = (dif.done === 1'b1);
    end

    logic [6:0] addr_log [$];
    logic [6:0] addr_prev = '0;

    always @(negedge clk) begin
        if (dif.busy === 1'b1 && {dif.ry, dif.rx} !== addr_prev)
            addr_log.push_back({dif.ry, dif.rx});
        addr_prev = {dif.ry, dif.rx};
    end

    function automatic logic [7:0] exp_byte(input int idx);
        int row = (idx % NBYTES) / 34;
        int col = (idx % NBYTES) % 34;
        logic [7:0] c;
        if (col == 32) return 8'h0D;
        if (col == 33) return 8'h0A;
        c = ram[row][col];
        return (c inside {[8'h20:8'h7E]}) ? c : 8'h20;
    endfunction

    task automatic clear_logs();
        rx_bytes.delete();
        addr_log.delete();
        frame_err     = 0;
        done_cnt      = 0;
        done_busy_err = 0;
        done_wide_err = 0;
    endtask

    task automatic pulse_start();
        @(posedge clk);
        #1 dif.start = 1'b1;
        @(posedge clk);
        #1 dif.start = 1'b0;
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < BUDGET; i++) begin
            @(negedge clk);
            if (dif.done === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        dif.start = 1'b0;
        reset     = 1'b0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 32; c++)
                ram[r][c] = 8'h00;
        ram[0][0] = 8'h41;
        ram[0][1] = 8'h07;
        ram[0][2] = 8'h7F;
        ram[0][3] = 8'h7E;
        ram[1][0] = 8'h1F;
        ram[1][5] = 8'h80;
        ram[2][0] = 8'h20;
        ram[2][31] = 8'h7E;
        ram[3][31] = 8'h5A;
        repeat (3) @(negedge clk);
        #1;
        checks++; if (dif.tx !== 1'b1) $display("FAIL reset_tx: got %b want 1", dif.tx); else passes++;
        checks++; if (dif.busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", dif.busy); else passes++;
        checks++; if (dif.done !== 1'b0) $display("FAIL reset_done: got %b want 0", dif.done); else passes++;
        checks++; if (dif.ry !== 2'd0) $display("FAIL reset_ry: got %0d want 0", dif.ry); else passes++;
        checks++; if (dif.rx !== 5'd0) $display("FAIL reset_rx: got %0d want 0", dif.rx); else passes++;
        reset = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_first_frame();
        logic [9:0] frame;
        bit found;
        bit bad;
        logic got;
        frame = {1'b1, 8'h41, 1'b0};
        clear_logs();
        pulse_start();
        checks++; if (dif.busy !== 1'b1) $display("FAIL busy_after_start: got %b want 1", dif.busy); else passes++;
        found = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (dif.tx === 1'b0) begin
                found = 1'b1;
                break;
            end
        end
        checks++; if (!found) $display("FAIL first_start_bit: got no start bit want tx=0 within 50 clks"); else passes++;
        for (int b = 0; b < 10; b++) begin
            bad = 1'b0;
            got = frame[b];
            for (int s = 0; s < 10; s++) begin
                if (b != 0 || s != 0) @(negedge clk);
                if (dif.tx !== frame[b] && !bad) begin
                    bad = 1'b1;
                    got = dif.tx;
                end
            end
            checks++;
            if (bad) $display("FAIL first_frame_bit%0d: got %b want %b for 10 clks", b, got, frame[b]);
            else passes++;
        end
    endtask

    task automatic test_full_dump();
        bit ok;
        int bad;
        int first_bad;
        wait_done(ok);
        checks++; if (!ok) $display("FAIL dump_done_timeout: got no done want done within %0d clks", BUDGET); else passes++;
        repeat (5) @(negedge clk);
        checks++; if (rx_bytes.size() != NBYTES) $display("FAIL dump_count: got %0d want %0d", rx_bytes.size(), NBYTES); else passes++;
        if (rx_bytes.size() >= NBYTES) begin
            checks++; if (rx_bytes[1] !== 8'h20) $display("FAIL subst_07: got %h want 20", rx_bytes[1]); else passes++;
            checks++; if (rx_bytes[2] !== 8'h20) $display("FAIL subst_7f: got %h want 20", rx_bytes[2]); else passes++;
            checks++; if (rx_bytes[3] !== 8'h7E) $display("FAIL keep_7e: got %h want 7e", rx_bytes[3]); else passes++;
            checks++; if (rx_bytes[4] !== 8'h20) $display("FAIL blank_cell: got %h want 20", rx_bytes[4]); else passes++;
            checks++; if (rx_bytes[32] !== 8'h0D) $display("FAIL byte33_cr: got %h want 0d", rx_bytes[32]); else passes++;
            checks++; if (rx_bytes[33] !== 8'h0A) $display("FAIL byte34_lf: got %h want 0a", rx_bytes[33]); else passes++;
            checks++; if (rx_bytes[134] !== 8'h0D) $display("FAIL last_cr: got %h want 0d", rx_bytes[134]); else passes++;
            checks++; if (rx_bytes[135] !== 8'h0A) $display("FAIL last_lf: got %h want 0a", rx_bytes[135]); else passes++;
            bad = 0;
            first_bad = -1;
            for (int i = 0; i < NBYTES; i++) begin
                if (rx_bytes[i] !== exp_byte(i)) begin
                    bad++;
                    if (first_bad < 0) first_bad = i;
                end
            end
            checks++;
            if (bad != 0) $display("FAIL dump_bytes: got %0d wrong bytes (first at %0d: %h) want %h", bad, first_bad, rx_bytes[first_bad], exp_byte(first_bad));
            else passes++;
        end
        checks++; if (frame_err != 0) $display("FAIL dump_framing: got %0d framing errors want 0", frame_err); else passes++;
        checks++; if (done_cnt != 1) $display("FAIL done_pulses: got %0d want 1", done_cnt); else passes++;
        checks++; if (done_wide_err != 0) $display("FAIL done_width: got %0d wide pulses want 0", done_wide_err); else passes++;
        checks++; if (done_busy_err != 0) $display("FAIL busy_at_done: got busy high %0d times want 0", done_busy_err); else passes++;
        bad = 0;
        for (int k = 0; k < addr_log.size() && k < 127; k++)
            if (addr_log[k] !== 7'(k + 1)) bad++;
        checks++;
        if (addr_log.size() != 127 || bad != 0)
            $display("FAIL addr_sequence: got %0d changes with %0d out of order want 127 in order", addr_log.size(), bad);
        else passes++;
    endtask

    task automatic test_back_to_back();
        bit ok;
        clear_logs();
        @(posedge clk);
        #1 dif.start = 1'b1;
        wait_done(ok);
        checks++; if (!ok) $display("FAIL b2b_done1_timeout: got no done want done within %0d clks", BUDGET); else passes++;
        checks++; if (rx_bytes.size() != NBYTES) $display("FAIL b2b_first_count: got %0d want %0d", rx_bytes.size(), NBYTES); else passes++;
        @(negedge clk);
        checks++; if (dif.busy !== 1'b0) $display("FAIL b2b_idle_gap: got busy %b want 0", dif.busy); else passes++;
        @(negedge clk);
        checks++; if (dif.busy !== 1'b1) $display("FAIL b2b_restart: got busy %b want 1", dif.busy); else passes++;
        @(posedge clk);
        #1 dif.start = 1'b0;
        wait_done(ok);
        checks++; if (!ok) $display("FAIL b2b_done2_timeout: got no done want done within %0d clks", BUDGET); else passes++;
        repeat (20) @(negedge clk);
        checks++; if (rx_bytes.size() != 2 * NBYTES) $display("FAIL b2b_total_count: got %0d want %0d", rx_bytes.size(), 2 * NBYTES); else passes++;
        checks++; if (done_cnt != 2) $display("FAIL b2b_done_pulses: got %0d want 2", done_cnt); else passes++;
        checks++; if (dif.busy !== 1'b0) $display("FAIL b2b_no_third: got busy %b want 0", dif.busy); else passes++;
        if (rx_bytes.size() > NBYTES) begin
            checks++;
            if (rx_bytes[NBYTES] !== 8'h41) $display("FAIL b2b_second_first: got %h want 41", rx_bytes[NBYTES]);
            else passes++;
        end
    endtask

    task automatic test_reset_mid_dump();
        bit ok;
        bit found;
        int bad;
        clear_logs();
        pulse_start();
        ok = 1'b0;
        for (int i = 0; i < BUDGET; i++) begin
            @(negedge clk);
            if (rx_bytes.size() == 9) begin
                ok = 1'b1;
                break;
            end
        end
        checks++; if (!ok) $display("FAIL rst_reach_byte10: got %0d bytes want 9 before timeout", rx_bytes.size()); else passes++;
        found = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (dif.tx === 1'b0) begin
                found = 1'b1;
                break;
            end
        end
        checks++; if (!found) $display("FAIL rst_byte10_start: got no start bit want tx=0 within 50 clks"); else passes++;
        repeat (50) @(negedge clk);
        checks++; if (dif.tx !== 1'b0) $display("FAIL rst_bit4_level: got %b want 0", dif.tx); else passes++;
        checks++; if (dif.rx !== 5'd9) $display("FAIL rst_pre_rx: got %0d want 9", dif.rx); else passes++;
        #1 reset = 1'b0;
        #1;
        checks++; if (dif.tx !== 1'b1) $display("FAIL rst_async_tx: got %b want 1", dif.tx); else passes++;
        checks++; if (dif.busy !== 1'b0) $display("FAIL rst_async_busy: got %b want 0", dif.busy); else passes++;
        checks++; if (dif.ry !== 2'd0) $display("FAIL rst_async_ry: got %0d want 0", dif.ry); else passes++;
        checks++; if (dif.rx !== 5'd0) $display("FAIL rst_async_rx: got %0d want 0", dif.rx); else passes++;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        clear_logs();
        pulse_start();
        wait_done(ok);
        checks++; if (!ok) $display("FAIL rst_redump_timeout: got no done want done within %0d clks", BUDGET); else passes++;
        repeat (5) @(negedge clk);
        checks++; if (rx_bytes.size() != NBYTES) $display("FAIL rst_redump_count: got %0d want %0d", rx_bytes.size(), NBYTES); else passes++;
        if (rx_bytes.size() > 0) begin
            checks++; if (rx_bytes[0] !== 8'h41) $display("FAIL rst_redump_first: got %h want 41", rx_bytes[0]); else passes++;
        end
        bad = 0;
        for (int i = 0; i < rx_bytes.size() && i < NBYTES; i++)
            if (rx_bytes[i] !== exp_byte(i)) bad++;
        checks++; if (bad != 0) $display("FAIL rst_redump_bytes: got %0d wrong bytes want 0", bad); else passes++;
        checks++; if (frame_err != 0) $display("FAIL rst_redump_framing: got %0d framing errors want 0", frame_err); else passes++;
    endtask

    initial begin
        dif.start = 1'b0;
        test_reset();
        test_first_frame();
        test_full_dump();
        test_back_to_back();
        test_reset_mid_dump();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
